// File: rtl/alu_rs_pkg.sv
// Shared types and helpers for the ALU reservation station bank.
package alu_rs_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_AND = 2'b10;
  localparam alu_op_t OP_XOR = 2'b11;

  // Widest datapath alu_compute handles; callers truncate to their own width.
  localparam int unsigned MAX_DW = 16;

  // Per-entry status record.
  typedef struct packed {
    logic reserved;
    logic a_valid;
    logic b_valid;
  } entry_flags_t;

  // Wraps naturally; truncating the result to a narrower width keeps it mod 2^width.
  function automatic logic [MAX_DW-1:0] alu_compute(alu_op_t op, logic [MAX_DW-1:0] a,
                                                    logic [MAX_DW-1:0] b);
    logic [MAX_DW-1:0] res;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      default: res = a ^ b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_bank_if.sv
// Dispatch, CDB snoop and CDB producer signals of the ALU reservation station bank.
interface alu_rs_bank_if #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4,
  parameter int unsigned NUM_ENTRIES   = 4
);
  import alu_rs_pkg::*;

  logic                     cdb_in_valid;
  logic [CDB_TAG_WIDTH-1:0] cdb_in_tag;
  logic [DATA_WIDTH-1:0]    cdb_in_data;
  logic                     cmd_valid;
  logic                     cmd_ready;
  alu_op_t                  cmd_op;
  logic [DATA_WIDTH-1:0]    cmd_a_data;
  logic                     cmd_a_is_valid;
  logic [DATA_WIDTH-1:0]    cmd_b_data;
  logic                     cmd_b_is_valid;
  logic [CDB_TAG_WIDTH-1:0] cmd_tag;
  logic                     cdb_out_request;
  logic [CDB_TAG_WIDTH-1:0] cdb_out_tag;
  logic [DATA_WIDTH-1:0]    cdb_out_data;
  logic                     cdb_out_accepted;
  logic [NUM_ENTRIES-1:0]   busy;

  // Reservation station side.
  modport slave (
    input  cdb_in_valid, cdb_in_tag, cdb_in_data,
    input  cmd_valid, cmd_op, cmd_a_data, cmd_a_is_valid, cmd_b_data, cmd_b_is_valid,
    input  cdb_out_accepted,
    output cmd_ready, cmd_tag, cdb_out_request, cdb_out_tag, cdb_out_data, busy
  );

  // Dispatch / CDB side.
  modport master (
    output cdb_in_valid, cdb_in_tag, cdb_in_data,
    output cmd_valid, cmd_op, cmd_a_data, cmd_a_is_valid, cmd_b_data, cmd_b_is_valid,
    output cdb_out_accepted,
    input  cmd_ready, cmd_tag, cdb_out_request, cdb_out_tag, cdb_out_data, busy
  );

endinterface

// File: rtl/alu_rs_entry.sv
// One reservation station entry: op, two operand/valid pairs and CDB snoop.
// A not-yet-valid operand keeps its producer tag in the low CDB_TAG_WIDTH data bits.
module alu_rs_entry
  import alu_rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_i,
  input  logic                     free_i,
  input  alu_op_t                  op_i,
  input  logic [DATA_WIDTH-1:0]    a_data_i,
  input  logic                     a_is_valid_i,
  input  logic [DATA_WIDTH-1:0]    b_data_i,
  input  logic                     b_is_valid_i,
  input  logic                     cdb_valid_i,
  input  logic [CDB_TAG_WIDTH-1:0] cdb_tag_i,
  input  logic [DATA_WIDTH-1:0]    cdb_data_i,
  output logic                     busy_o,
  output logic                     ready_o,
  output alu_op_t                  op_o,
  output logic [DATA_WIDTH-1:0]    a_o,
  output logic [DATA_WIDTH-1:0]    b_o
);

  entry_flags_t          flags_q, flags_d;
  alu_op_t               op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;

  // Next state: dispatch (with same-cycle CDB capture), free, or snoop.
  always_comb begin
    flags_d = flags_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    if (alloc_i) begin
      flags_d.reserved = 1'b1;
      op_d             = op_i;
      a_d              = a_data_i;
      flags_d.a_valid  = a_is_valid_i;
      b_d              = b_data_i;
      flags_d.b_valid  = b_is_valid_i;
      if (!a_is_valid_i && cdb_valid_i && a_data_i[CDB_TAG_WIDTH-1:0] == cdb_tag_i) begin
        a_d             = cdb_data_i;
        flags_d.a_valid = 1'b1;
      end
      if (!b_is_valid_i && cdb_valid_i && b_data_i[CDB_TAG_WIDTH-1:0] == cdb_tag_i) begin
        b_d             = cdb_data_i;
        flags_d.b_valid = 1'b1;
      end
    end else if (free_i) begin
      flags_d = '0;
    end else if (flags_q.reserved) begin
      if (!flags_q.a_valid && cdb_valid_i && a_q[CDB_TAG_WIDTH-1:0] == cdb_tag_i) begin
        a_d             = cdb_data_i;
        flags_d.a_valid = 1'b1;
      end
      if (!flags_q.b_valid && cdb_valid_i && b_q[CDB_TAG_WIDTH-1:0] == cdb_tag_i) begin
        b_d             = cdb_data_i;
        flags_d.b_valid = 1'b1;
      end
    end
  end

  // Entry state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      flags_q <= flags_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy_o  = flags_q.reserved;
  assign ready_o = flags_q.reserved & flags_q.a_valid & flags_q.b_valid;
  assign op_o    = op_q;
  assign a_o     = a_q;
  assign b_o     = b_q;

endmodule

// File: rtl/alu_rs_bank.sv
// ALU reservation station bank: free-slot encoder, issue arbiter with lock, result mux.
// Build option ALU_RS_AGE_ORDER_EN: issue picks the oldest ready entry via an age matrix;
// without it the lowest ready index wins.
module alu_rs_bank
  import alu_rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4,
  parameter int unsigned NUM_ENTRIES   = 4,
  parameter int unsigned RS_TAG_BASE   = 0
) (
  input logic          clk,
  input logic          rst_n,
  alu_rs_bank_if.slave bus
);

  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] busy, ready, alloc, free;
  alu_op_t                op_e  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  a_e   [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  b_e   [NUM_ENTRIES];

  logic            dispatch;
  logic [IdxW-1:0] free_idx;
  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  logic            req;
  logic [IdxW-1:0] sel_idx;
  logic            accept;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    alu_rs_entry #(
      .DATA_WIDTH    (DATA_WIDTH),
      .CDB_TAG_WIDTH (CDB_TAG_WIDTH)
    ) u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc_i      (alloc[i]),
      .free_i       (free[i]),
      .op_i         (bus.cmd_op),
      .a_data_i     (bus.cmd_a_data),
      .a_is_valid_i (bus.cmd_a_is_valid),
      .b_data_i     (bus.cmd_b_data),
      .b_is_valid_i (bus.cmd_b_is_valid),
      .cdb_valid_i  (bus.cdb_in_valid),
      .cdb_tag_i    (bus.cdb_in_tag),
      .cdb_data_i   (bus.cdb_in_data),
      .busy_o       (busy[i]),
      .ready_o      (ready[i]),
      .op_o         (op_e[i]),
      .a_o          (a_e[i]),
      .b_o          (b_e[i])
    );
  end

  // Lowest-index free entry, from registered busy only.
  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!busy[i] && !found) begin
        found    = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  assign bus.cmd_ready = ~&busy;
  assign bus.cmd_tag   = CDB_TAG_WIDTH'(RS_TAG_BASE) + CDB_TAG_WIDTH'(free_idx);
  assign dispatch      = bus.cmd_valid & bus.cmd_ready;
  assign alloc         = dispatch ? (NUM_ENTRIES'(1) << free_idx) : '0;

`ifdef ALU_RS_AGE_ORDER_EN
  // older_q[i][j]: entry i was dispatched before entry j.
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];

  // A new dispatch is younger than every other entry; stale rows of free entries are masked
  // by ready and rewritten on their next dispatch.
  always_comb begin
    older_d = older_q;
    if (dispatch) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        older_d[free_idx][j] = 1'b0;
        if (IdxW'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk) begin
    if (!rst_n) older_q <= '{default: '0};
    else        older_q <= older_d;
  end

  // Oldest ready entry: older than every other ready entry.
  always_comb begin
    logic oldest;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      oldest = ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && ready[j] && !older_q[i][j]) oldest = 1'b0;
      end
      if (oldest && !arb_found) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end
  end
`else
  // Fixed priority: lowest ready index.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ready[i] && !arb_found) begin
        arb_found = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end
  end
`endif

  assign req     = lock_q | arb_found;
  assign sel_idx = lock_q ? lock_idx_q : arb_idx;
  assign accept  = req & bus.cdb_out_accepted;
  assign free    = accept ? (NUM_ENTRIES'(1) << sel_idx) : '0;

  // Lock holds a presented selection until the CDB grants it.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      lock_d = 1'b0;
    end else if (req) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
  end

  // Lock register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  logic [MAX_DW-1:0] res_full;
  logic              unused_res;

  assign res_full = alu_compute(op_e[sel_idx], MAX_DW'(a_e[sel_idx]), MAX_DW'(b_e[sel_idx]));
  assign unused_res = ^res_full[MAX_DW-1:DATA_WIDTH];

  assign bus.cdb_out_request = req;
  assign bus.cdb_out_tag     = CDB_TAG_WIDTH'(RS_TAG_BASE) + CDB_TAG_WIDTH'(sel_idx);
  assign bus.cdb_out_data    = res_full[DATA_WIDTH-1:0];
  assign bus.busy            = busy;

endmodule

// File: tb/tb_alu_rs_bank.sv
// Self-checking bench for alu_rs_bank: directed scenarios plus random traffic against a
// transaction-level model of the station.
module tb_alu_rs_bank;
  import alu_rs_pkg::*;

  localparam int DW   = 4;
  localparam int CTW  = 4;
  localparam int NE   = 4;
  localparam int MASK = (1 << DW) - 1;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_rs_bank_if #(.DATA_WIDTH(DW), .CDB_TAG_WIDTH(CTW), .NUM_ENTRIES(NE)) bus ();

  alu_rs_bank #(
    .DATA_WIDTH    (DW),
    .CDB_TAG_WIDTH (CTW),
    .NUM_ENTRIES   (NE),
    .RS_TAG_BASE   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_busy [NE];
  bit m_av   [NE];
  bit m_bv   [NE];
  int m_op   [NE];
  int m_a    [NE];
  int m_b    [NE];
  int m_seq  [NE];
  int m_next_seq;
  bit m_lock;
  int m_lidx;

  function automatic int model_alu(int op, int a, int b);
    case (op)
      0:       return (a + b) & MASK;
      1:       return (a - b) & MASK;
      2:       return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) begin
      m_busy[i] = 0; m_av[i] = 0; m_bv[i] = 0;
    end
    m_lock = 0; m_lidx = 0; m_next_seq = 0;
  endfunction

  function automatic void model_expect(output bit e_rdy, output int e_tag, output bit e_req,
                                       output int e_sel, output int e_data);
    e_rdy = 0; e_tag = 0;
    for (int i = NE - 1; i >= 0; i--) if (!m_busy[i]) begin e_rdy = 1; e_tag = i; end
    e_req = 0; e_sel = 0;
    if (m_lock) begin
      e_req = 1; e_sel = m_lidx;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (m_busy[i] && m_av[i] && m_bv[i]) begin
`ifdef ALU_RS_AGE_ORDER_EN
          if (!e_req || m_seq[i] < m_seq[e_sel]) begin e_req = 1; e_sel = i; end
`else
          if (!e_req) begin e_req = 1; e_sel = i; end
`endif
        end
      end
    end
    e_data = model_alu(m_op[e_sel], m_a[e_sel], m_b[e_sel]);
  endfunction

  function automatic void model_edge(bit rst, bit cv, int op, int a, bit av, int b, bit bv,
                                     bit dv, int dt, int dd, bit acc);
    bit e_rdy, e_req;
    int e_tag, e_sel, e_data;
    if (!rst) begin model_reset(); return; end
    model_expect(e_rdy, e_tag, e_req, e_sel, e_data);
    for (int i = 0; i < NE; i++) begin
      if (m_busy[i] && dv && !m_av[i] && m_a[i] == dt) begin m_a[i] = dd; m_av[i] = 1; end
      if (m_busy[i] && dv && !m_bv[i] && m_b[i] == dt) begin m_b[i] = dd; m_bv[i] = 1; end
    end
    if (e_req && acc) begin m_busy[e_sel] = 0; m_lock = 0; end
    else if (e_req) begin m_lock = 1; m_lidx = e_sel; end
    if (cv && e_rdy) begin
      m_busy[e_tag] = 1; m_op[e_tag] = op; m_seq[e_tag] = m_next_seq++;
      m_a[e_tag] = a; m_av[e_tag] = av; m_b[e_tag] = b; m_bv[e_tag] = bv;
      if (!av && dv && a == dt) begin m_a[e_tag] = dd; m_av[e_tag] = 1; end
      if (!bv && dv && b == dt) begin m_b[e_tag] = dd; m_bv[e_tag] = 1; end
    end
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(bit v, alu_op_t op, int a, bit av, int b, bit bv);
    bus.cmd_valid      = v;
    bus.cmd_op         = op;
    bus.cmd_a_data     = DW'(a);
    bus.cmd_a_is_valid = av;
    bus.cmd_b_data     = DW'(b);
    bus.cmd_b_is_valid = bv;
  endtask

  task automatic set_cdb(bit v, int t, int d);
    bus.cdb_in_valid = v;
    bus.cdb_in_tag   = CTW'(t);
    bus.cdb_in_data  = DW'(d);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    set_cdb(0, 0, 0);
    bus.cdb_out_accepted = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_cmd(1, OP_ADD, 1, 1, 1, 1);
    set_cdb(0, 0, 0);
    bus.cdb_out_accepted = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 4'b0000) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0000", bus.busy);
    end
    n_tests++;
    if (bus.cdb_out_request !== 1'b0) begin
      n_fail++; $display("FAIL reset_request: got %b want 0", bus.cdb_out_request);
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    apply_reset();
    set_cmd(1, OP_ADD, 3, 1, 2, 1);
    #1;
    n_tests++;
    if (bus.cmd_tag !== 4'd0 || bus.cdb_out_request !== 1'b0) begin
      n_fail++; $display("FAIL add_dispatch: got tag %0d req %b want tag 0 req 0",
                         bus.cmd_tag, bus.cdb_out_request);
    end
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_tag !== 4'd0 || bus.cdb_out_data !== 4'd5) begin
      n_fail++; $display("FAIL add_issue: got req %b tag %0d data %0d want 1 0 5",
                         bus.cdb_out_request, bus.cdb_out_tag, bus.cdb_out_data);
    end
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 4'b0000 || bus.cdb_out_request !== 1'b0) begin
      n_fail++; $display("FAIL add_free: got busy %b req %b want 0000 0",
                         bus.busy, bus.cdb_out_request);
    end
  endtask

  task automatic test_pending_operand();
    apply_reset();
    set_cmd(1, OP_SUB, 9, 0, 1, 1);
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b0) begin
      n_fail++; $display("FAIL pending_no_req: got %b want 0", bus.cdb_out_request);
    end
    set_cdb(1, 9, 7);
    tick();
    set_cdb(0, 0, 0);
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_tag !== 4'd0 || bus.cdb_out_data !== 4'd6) begin
      n_fail++; $display("FAIL pending_wake: got req %b tag %0d data %0d want 1 0 6",
                         bus.cdb_out_request, bus.cdb_out_tag, bus.cdb_out_data);
    end
  endtask

  task automatic test_same_cycle_capture();
    apply_reset();
    set_cmd(1, OP_ADD, 9, 0, 2, 1);
    set_cdb(1, 9, 4);
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    set_cdb(0, 0, 0);
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_data !== 4'd6) begin
      n_fail++; $display("FAIL same_cycle_capture: got req %b data %0d want 1 6",
                         bus.cdb_out_request, bus.cdb_out_data);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < NE; i++) begin
      set_cmd(1, OP_ADD, 8 + i, 0, 1, 1);
      #1;
      n_tests++;
      if (bus.cmd_ready !== 1'b1 || bus.cmd_tag !== 4'(i)) begin
        n_fail++; $display("FAIL fill_tag%0d: got ready %b tag %0d want 1 %0d",
                           i, bus.cmd_ready, bus.cmd_tag, i);
      end
      tick();
    end
    set_cmd(1, OP_XOR, 5, 1, 5, 1);
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 4'b1111) begin
      n_fail++; $display("FAIL full_ready: got ready %b busy %b want 0 1111",
                         bus.cmd_ready, bus.busy);
    end
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.busy !== 4'b1111 || bus.cdb_out_request !== 1'b0) begin
      n_fail++; $display("FAIL full_ignore: got busy %b req %b want 1111 0",
                         bus.busy, bus.cdb_out_request);
    end
    set_cdb(1, 9, 7);
    tick();
    set_cdb(0, 0, 0);
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_tag !== 4'd1 || bus.cdb_out_data !== 4'd8) begin
      n_fail++; $display("FAIL full_wake: got req %b tag %0d data %0d want 1 1 8",
                         bus.cdb_out_request, bus.cdb_out_tag, bus.cdb_out_data);
    end
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.cmd_tag !== 4'd1 || bus.busy !== 4'b1101) begin
      n_fail++; $display("FAIL full_free: got ready %b tag %0d busy %b want 1 1 1101",
                         bus.cmd_ready, bus.cmd_tag, bus.busy);
    end
    set_cmd(1, OP_AND, 6, 1, 3, 1);
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.busy !== 4'b1111 || bus.cdb_out_tag !== 4'd1 || bus.cdb_out_data !== 4'd2) begin
      n_fail++; $display("FAIL full_reuse: got busy %b tag %0d data %0d want 1111 1 2",
                         bus.busy, bus.cdb_out_tag, bus.cdb_out_data);
    end
  endtask

  task automatic test_lock();
    int first_tag, first_data, second_tag, second_data;
    apply_reset();
    set_cmd(1, OP_ADD, 1, 1, 1, 1);   // e0, ready at once
    tick();
    set_cmd(1, OP_ADD, 13, 0, 0, 1);  // e1, never woken
    tick();
    set_cmd(1, OP_XOR, 9, 0, 5, 1);   // e2
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    set_cmd(1, OP_AND, 9, 0, 6, 1);   // e0 again, now younger than e2
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    set_cdb(1, 9, 12);                // e0 and e2 wake together
    tick();
    set_cdb(0, 0, 0);
`ifdef ALU_RS_AGE_ORDER_EN
    first_tag = 2; first_data = 9; second_tag = 0; second_data = 4;
`else
    first_tag = 0; first_data = 4; second_tag = 2; second_data = 9;
`endif
    #1;
    n_tests++;
    if (bus.cdb_out_tag !== 4'(first_tag) || bus.cdb_out_data !== 4'(first_data)) begin
      n_fail++; $display("FAIL tie_first: got tag %0d data %0d want %0d %0d",
                         bus.cdb_out_tag, bus.cdb_out_data, first_tag, first_data);
    end
    bus.cdb_out_accepted = 1'b1;
    tick();
    #1;
    n_tests++;
    if (bus.cdb_out_tag !== 4'(second_tag) || bus.cdb_out_data !== 4'(second_data)) begin
      n_fail++; $display("FAIL tie_second: got tag %0d data %0d want %0d %0d",
                         bus.cdb_out_tag, bus.cdb_out_data, second_tag, second_data);
    end
    tick();
    bus.cdb_out_accepted = 1'b0;
    // Entry 2 wakes first, entry 0 one cycle later; the lock must hold entry 2.
    set_cmd(1, OP_SUB, 8, 0, 1, 1);   // e0
    tick();
    set_cmd(1, OP_ADD, 9, 0, 2, 1);   // e2
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    set_cdb(1, 9, 3);
    tick();
    set_cdb(1, 8, 5);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_tag !== 4'd2 || bus.cdb_out_data !== 4'd5) begin
        n_fail++; $display("FAIL lock_hold%0d: got req %b tag %0d data %0d want 1 2 5",
                           c, bus.cdb_out_request, bus.cdb_out_tag, bus.cdb_out_data);
      end
      tick();
      set_cdb(0, 0, 0);
    end
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_tag !== 4'd0 || bus.cdb_out_data !== 4'd4) begin
      n_fail++; $display("FAIL lock_next: got req %b tag %0d data %0d want 1 0 4",
                         bus.cdb_out_request, bus.cdb_out_tag, bus.cdb_out_data);
    end
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 4'b0010 || bus.cdb_out_request !== 1'b0) begin
      n_fail++; $display("FAIL lock_drain: got busy %b req %b want 0010 0",
                         bus.busy, bus.cdb_out_request);
    end
  endtask

  task automatic test_reset_pending();
    apply_reset();
    set_cmd(1, OP_SUB, 0, 1, 1, 1);
    tick();
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b1 || bus.cdb_out_data !== 4'hF) begin
      n_fail++; $display("FAIL sub_wrap: got req %b data %h want 1 f",
                         bus.cdb_out_request, bus.cdb_out_data);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.cdb_out_request !== 1'b0 || bus.busy !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pending: got req %b busy %b want 0 0000",
                         bus.cdb_out_request, bus.busy);
    end
  endtask

  task automatic test_random();
    int  tag_pool [6] = '{0, 1, 2, 3, 9, 10};
    bit  fb_v;
    int  fb_t, fb_d;
    bit  cv, av, bv, dv, acc;
    int  op, a, b, dt, dd;
    bit  e_rdy, e_req;
    int  e_tag, e_sel, e_data;
    logic [NE-1:0] e_busy;
    apply_reset();
    model_reset();
    fb_v = 0; fb_t = 0; fb_d = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      cv  = 1'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 3));
      av  = ($urandom_range(0, 9) < 7);
      bv  = ($urandom_range(0, 9) < 7);
      a   = av ? int'($urandom_range(0, MASK)) : tag_pool[$urandom_range(0, 5)];
      b   = bv ? int'($urandom_range(0, MASK)) : tag_pool[$urandom_range(0, 5)];
      acc = 1'($urandom_range(0, 1));
      if (fb_v) begin
        dv = 1; dt = fb_t; dd = fb_d;
      end else begin
        dv = ($urandom_range(0, 9) < 4);
        dt = tag_pool[$urandom_range(0, 5)];
        dd = int'($urandom_range(0, MASK));
      end
      set_cmd(cv, alu_op_t'(op), a, av, b, bv);
      set_cdb(dv, dt, dd);
      bus.cdb_out_accepted = acc;
      #1;
      model_expect(e_rdy, e_tag, e_req, e_sel, e_data);
      for (int i = 0; i < NE; i++) e_busy[i] = m_busy[i];
      n_tests++;
      if (bus.busy !== e_busy) begin
        n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, bus.busy, e_busy);
      end
      n_tests++;
      if (bus.cmd_ready !== e_rdy) begin
        n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.cmd_ready, e_rdy);
      end
      if (e_rdy) begin
        n_tests++;
        if (bus.cmd_tag !== 4'(e_tag)) begin
          n_fail++; $display("FAIL rnd_cmd_tag c%0d: got %0d want %0d", cyc, bus.cmd_tag, e_tag);
        end
      end
      n_tests++;
      if (bus.cdb_out_request !== e_req) begin
        n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, bus.cdb_out_request, e_req);
      end
      if (e_req) begin
        n_tests++;
        if (bus.cdb_out_tag !== 4'(e_sel) || bus.cdb_out_data !== 4'(e_data)) begin
          n_fail++; $display("FAIL rnd_out c%0d: got tag %0d data %0d want %0d %0d",
                             cyc, bus.cdb_out_tag, bus.cdb_out_data, e_sel, e_data);
        end
      end
      fb_v = e_req && acc;
      fb_t = e_sel;
      fb_d = e_data;
      @(posedge clk);
      model_edge(1'b1, cv, op, a, av, b, bv, dv, dt, dd, acc);
      #1;
    end
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    set_cdb(0, 0, 0);
    bus.cdb_out_accepted = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_cmd(0, OP_ADD, 0, 0, 0, 0);
    set_cdb(0, 0, 0);
    bus.cdb_out_accepted = 1'b0;
    test_reset();
    test_add();
    test_pending_operand();
    test_same_cycle_capture();
    test_full();
    test_lock();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
